pe_mac_tile: RTL and testbench
==============================

# pe_mac_tile

Parametrised output-stationary processing element for the systolic matrix-multiply array, succeeding the fixed 8/16-bit PE. It forwards A operands east and B operands south one cycle behind, accumulates A×B only on valid operand pairs, and supports signed/unsigned operands, optional saturation, and tile boundaries marked by a last flag. Each finished dot product is held in a result register and drained through a per-column shift chain, so the array can begin the next tile while the previous results are unloaded.

## Interface
- DATA_WIDTH, 8, operand width; must be ≥ 2.
- ACC_WIDTH, 32, accumulator/result width; must be ≥ 2*DATA_WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global advance; 0 freezes every register in the block.
- signed_mode  in  1  1: operands and accumulator are two's complement; 0: unsigned.
- sat_en  in  1  1: saturate accumulation; 0: wrap modulo 2^ACC_WIDTH.
- a_in / b_in  in  DATA_WIDTH  operands from west / north.
- a_valid_in / b_valid_in  in  1  operand qualifiers.
- a_last_in  in  1  marks the final A element of the current tile.
- a_out / b_out  out  DATA_WIDTH  registered operand forward east / south.
- a_valid_out / b_valid_out / a_last_out  out  1  registered qualifier forwards.
- drain_load  in  1  copy the local result into the drain register.
- drain_shift  in  1  shift the drain chain: drain register takes c_in.
- c_in  in  ACC_WIDTH, c_valid_in  in  1, c_ovf_in  in  1  drain chain from the upstream PE in the column.
- c_out  out  ACC_WIDTH, c_valid_out  out  1, c_ovf_out  out  1  registered drain chain output.
- res_overrun  out  1  sticky: an unloaded result was overwritten.

## Operation
- Every register updates only on a rising clk edge with en=1; with en=0 all state and outputs hold.
- Forwarding: a_out, a_valid_out, a_last_out, b_out, and b_valid_out take their inputs unconditionally on every enabled edge, regardless of whether the inputs are valid.
- MAC fire = en & a_valid_in & b_valid_in. Product is 2*DATA_WIDTH wide: signed multiply when signed_mode=1, unsigned otherwise. The product is sign- or zero-extended to ACC_WIDTH+1 bits.
- Internal flag `first` is set by reset and by every fire with a_last_in=1. sum = (first ? 0 : acc) + product, computed in ACC_WIDTH+1 bits (ACC_WIDTH+2 in signed mode).
- Overflow means sum lies outside the signed range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] when signed_mode=1, or outside the unsigned range [0, 2^ACC_WIDTH-1] when signed_mode=0.
  - sat_en=1: acc takes the nearest range bound.
  - sat_en=0: acc takes sum truncated to ACC_WIDTH bits.
- The sticky tile overflow flag `ovf` = (first ? 0 : ovf) | overflow on each fire.
- A fire with a_last_in=1 commits the updated acc to res, commits ovf to res_ovf, and sets res_valid=1.
  - If res_valid was already 1 and no drain_load occurs on the same edge, res is overwritten and res_overrun is set until reset.
- Drain (drain_load has priority over drain_shift):
  - drain_load=1: c_out←res, c_ovf_out←res_ovf, c_valid_out←res_valid, then res_valid clears. Loading with res_valid=0 produces a bubble (c_valid_out=0).
  - drain_shift=1 (and drain_load=0): c_out, c_valid_out, and c_ovf_out take c_in, c_valid_in, and c_ovf_in.
  - Neither asserted: the drain register holds.
- Same-edge drain_load and last-commit: the drain register takes the old res; the new result lands in res with res_valid=1; no overrun is flagged.
- A mode change (signed_mode or sat_en) mid-tile is not supported. The sampled value applies per fire.

## Timing
- Reset (asynchronous, immediate) drives every output to 0, sets acc=0, res=0, res_valid=0, ovf=0, first=1.
- Operand/qualifier forward latency: 1 enabled cycle.
- Result latency: res is valid 1 cycle after the edge that fires with a_last_in. It appears on c_out 1 cycle after the drain_load edge.
- A column of N PEs drains in 1 load cycle plus N-1 shift cycles. A new tile may stream during the drain.
- Back-to-back tiles are supported: a fire with a_last_in followed directly by a fire starts the new tile with acc = product.
- Reset asserted mid-tile or mid-drain discards all partial and held results.

## Test plan
- Unsigned, DATA=8, ACC=16: fire (3,4), (2,5), (1,6 last), then drain_load → c_out=28, c_valid_out=1, c_ovf_out=0. Forwards lag inputs by 1 cycle.
- Signed: fire (-3,4), (2,-5 last) → c_out=0xFFEA (-22), c_ovf_out=0. Repeat with signed_mode=0 and operands 253,4 / 2,251 → 1514.
- Unsigned saturation, ACC=16: fire (255,255) twice with last → sat_en=1 gives 65535 with ovf=1; sat_en=0 gives 64514 with ovf=1.
- Signed saturation, ACC=16: fire (-128,-128) four times with last → 32767, ovf=1. The next tile (1,1 last) gives 1 with ovf=0, confirming first-clear.
- Stall and bubbles: drop a_valid_in for 2 cycles and hold en=0 for 3 cycles mid-tile → result equals the uninterrupted case, and all outputs are frozen during en=0.
- Drain and overrun: drive c_in=0x1234, c_valid_in=1, drain_shift=1 → c_out=0x1234 next cycle. Commit two tiles without drain_load → res_overrun=1. Assert rst_n=0 mid-tile → all outputs 0 immediately.

Source files
------------

// File: rtl/pe_mac_tile.sv
// Output-stationary systolic PE: forwards A east and B south, MACs on
// valid operand pairs, commits a result per tile and drains it south.
// Ports: clk/rst_n/en, signed_mode, sat_en, a_*/b_* operand streams
// and their registered forwards, drain_load/drain_shift, c_* drain
// chain in/out, res_overrun sticky flag.
module pe_mac_tile #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  signed_mode,
  input  logic                  sat_en,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  a_valid_in,
  input  logic                  b_valid_in,
  input  logic                  a_last_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  a_valid_out,
  output logic                  b_valid_out,
  output logic                  a_last_out,
  input  logic                  drain_load,
  input  logic                  drain_shift,
  input  logic [ACC_WIDTH-1:0]  c_in,
  input  logic                  c_valid_in,
  input  logic                  c_ovf_in,
  output logic [ACC_WIDTH-1:0]  c_out,
  output logic                  c_valid_out,
  output logic                  c_ovf_out,
  output logic                  res_overrun
);

  localparam int PW = 2 * DATA_WIDTH;
  // Two guard bits cover both the unsigned carry and signed range.
  localparam int SW = ACC_WIDTH + 2;

  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf;
  logic                 first;
  logic [ACC_WIDTH-1:0] res;
  logic                 res_ovf;
  logic                 res_valid;

  logic                 fire;
  logic                 commit;
  logic [PW-1:0]        prod_u;
  logic [PW-1:0]        prod_s;
  logic [SW-1:0]        prod_x;
  logic [SW-1:0]        base_x;
  logic [SW-1:0]        sum;
  logic [2:0]           top_s;
  logic                 over_s;
  logic                 over_u;
  logic                 overflow;
  logic [ACC_WIDTH-1:0] sat_val;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 ovf_next;

  assign fire   = en & a_valid_in & b_valid_in;
  assign commit = fire & a_last_in;

  assign prod_u = a_in * b_in;
  assign prod_s = $signed(a_in) * $signed(b_in);

  always_comb begin
    prod_x = {{(SW-PW){1'b0}}, prod_u};
    if (signed_mode)
      prod_x = {{(SW-PW){prod_s[PW-1]}}, prod_s};
  end

  always_comb begin
    base_x = '0;
    if (!first) begin
      if (signed_mode)
        base_x = {{2{acc[ACC_WIDTH-1]}}, acc};
      else
        base_x = {2'b00, acc};
    end
  end

  assign sum = base_x + prod_x;

  // In range for signed iff the guard bits match the result MSB.
  assign top_s  = sum[SW-1:ACC_WIDTH-1];
  assign over_s = (top_s != 3'b000) && (top_s != 3'b111);
  // Unsigned sums are never negative, so only a carry can overflow.
  assign over_u = |sum[SW-1:ACC_WIDTH];
  assign overflow = signed_mode ? over_s : over_u;

  always_comb begin
    sat_val = '1;
    if (signed_mode) begin
      if (sum[SW-1])
        sat_val = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else
        sat_val = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  assign acc_next = (overflow && sat_en) ? sat_val
                                         : sum[ACC_WIDTH-1:0];
  assign ovf_next = (~first & ovf) | overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out       <= '0;
      b_out       <= '0;
      a_valid_out <= 1'b0;
      b_valid_out <= 1'b0;
      a_last_out  <= 1'b0;
    end else if (en) begin
      a_out       <= a_in;
      b_out       <= b_in;
      a_valid_out <= a_valid_in;
      b_valid_out <= b_valid_in;
      a_last_out  <= a_last_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      ovf   <= 1'b0;
      first <= 1'b1;
    end else if (fire) begin
      acc   <= acc_next;
      ovf   <= ovf_next;
      first <= a_last_in;
    end
  end

  // A commit on the same edge as a load wins res_valid: the load
  // took the old result, the new one is now waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res         <= '0;
      res_ovf     <= 1'b0;
      res_valid   <= 1'b0;
      res_overrun <= 1'b0;
    end else if (en) begin
      if (commit) begin
        res       <= acc_next;
        res_ovf   <= ovf_next;
        res_valid <= 1'b1;
        if (res_valid && !drain_load)
          res_overrun <= 1'b1;
      end else if (drain_load) begin
        res_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_out       <= '0;
      c_valid_out <= 1'b0;
      c_ovf_out   <= 1'b0;
    end else if (en) begin
      if (drain_load) begin
        c_out       <= res;
        c_valid_out <= res_valid;
        c_ovf_out   <= res_ovf;
      end else if (drain_shift) begin
        c_out       <= c_in;
        c_valid_out <= c_valid_in;
        c_ovf_out   <= c_ovf_in;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_tile.sv
// Bench for pe_mac_tile at DATA_WIDTH=8, ACC_WIDTH=16: directed tiles
// with literal results, then random traffic against an arithmetic model.
module tb_pe_mac_tile;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          signed_mode = 1'b0;
  logic          sat_en = 1'b0;
  logic [DW-1:0] a_in = '0;
  logic [DW-1:0] b_in = '0;
  logic          a_valid_in = 1'b0;
  logic          b_valid_in = 1'b0;
  logic          a_last_in = 1'b0;
  logic [DW-1:0] a_out;
  logic [DW-1:0] b_out;
  logic          a_valid_out;
  logic          b_valid_out;
  logic          a_last_out;
  logic          drain_load = 1'b0;
  logic          drain_shift = 1'b0;
  logic [AW-1:0] c_in = '0;
  logic          c_valid_in = 1'b0;
  logic          c_ovf_in = 1'b0;
  logic [AW-1:0] c_out;
  logic          c_valid_out;
  logic          c_ovf_out;
  logic          res_overrun;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  pe_mac_tile #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .signed_mode(signed_mode), .sat_en(sat_en),
    .a_in(a_in), .b_in(b_in),
    .a_valid_in(a_valid_in), .b_valid_in(b_valid_in),
    .a_last_in(a_last_in),
    .a_out(a_out), .b_out(b_out),
    .a_valid_out(a_valid_out), .b_valid_out(b_valid_out),
    .a_last_out(a_last_out),
    .drain_load(drain_load), .drain_shift(drain_shift),
    .c_in(c_in), .c_valid_in(c_valid_in), .c_ovf_in(c_ovf_in),
    .c_out(c_out), .c_valid_out(c_valid_out),
    .c_ovf_out(c_ovf_out), .res_overrun(res_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic longint msum(input logic [DW-1:0] a,
      input logic [DW-1:0] b, input logic sm, input logic fst,
      input logic [AW-1:0] acc);
    longint pa, pb, base;
    pa = sm ? longint'($signed(a)) : longint'(a);
    pb = sm ? longint'($signed(b)) : longint'(b);
    base = 0;
    if (!fst) base = sm ? longint'($signed(acc)) : longint'(acc);
    return base + pa * pb;
  endfunction

  function automatic longint lo_b(input logic sm);
    return sm ? -(longint'(1) <<< (AW-1)) : 0;
  endfunction

  function automatic longint hi_b(input logic sm);
    return sm ? (longint'(1) <<< (AW-1)) - 1
              : (longint'(1) <<< AW) - 1;
  endfunction

  function automatic logic over(input longint s, input logic sm);
    return (s < lo_b(sm)) || (s > hi_b(sm));
  endfunction

  function automatic logic [AW-1:0] clamp(input longint s,
      input logic sm, input logic sat);
    longint r;
    r = s;
    if (sat && s > hi_b(sm)) r = hi_b(sm);
    if (sat && s < lo_b(sm)) r = lo_b(sm);
    return r[AW-1:0];
  endfunction

  logic [DW-1:0] m_a, m_b;
  logic          m_av, m_bv, m_al;
  logic [AW-1:0] m_acc, m_res, m_c;
  logic          m_ovf, m_first, m_res_ovf, m_rv, m_orun;
  logic          m_cv, m_co;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0;
      m_av <= 0; m_bv <= 0; m_al <= 0;
      m_acc <= '0; m_res <= '0; m_c <= '0;
      m_ovf <= 0; m_first <= 1; m_res_ovf <= 0;
      m_rv <= 0; m_orun <= 0; m_cv <= 0; m_co <= 0;
    end else if (en) begin
      m_a <= a_in; m_b <= b_in;
      m_av <= a_valid_in; m_bv <= b_valid_in;
      m_al <= a_last_in;
      if (drain_load) begin
        m_c <= m_res; m_cv <= m_rv; m_co <= m_res_ovf;
        m_rv <= 0;
      end else if (drain_shift) begin
        m_c <= c_in; m_cv <= c_valid_in; m_co <= c_ovf_in;
      end
      if (a_valid_in && b_valid_in) begin
        m_acc <= clamp(msum(a_in, b_in, signed_mode, m_first,
                            m_acc), signed_mode, sat_en);
        m_ovf <= (!m_first && m_ovf) |
                 over(msum(a_in, b_in, signed_mode, m_first,
                           m_acc), signed_mode);
        m_first <= a_last_in;
        if (a_last_in) begin
          m_res <= clamp(msum(a_in, b_in, signed_mode, m_first,
                              m_acc), signed_mode, sat_en);
          m_res_ovf <= (!m_first && m_ovf) |
                       over(msum(a_in, b_in, signed_mode,
                                 m_first, m_acc), signed_mode);
          m_rv <= 1;
          if (m_rv && !drain_load) m_orun <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("a_out", a_out, m_a);
      chk("b_out", b_out, m_b);
      chk("a_valid_out", a_valid_out, m_av);
      chk("b_valid_out", b_valid_out, m_bv);
      chk("a_last_out", a_last_out, m_al);
      chk("c_out", c_out, m_c);
      chk("c_valid_out", c_valid_out, m_cv);
      chk("c_ovf_out", c_ovf_out, m_co);
      chk("res_overrun", res_overrun, m_orun);
    end
  end

  task automatic cyc(input logic [DW-1:0] a, input logic [DW-1:0] b,
      input logic av, input logic bv, input logic l,
      input logic dl, input logic ds);
    a_in = a; b_in = b;
    a_valid_in = av; b_valid_in = bv; a_last_in = l;
    drain_load = dl; drain_shift = ds;
    @(negedge clk);
  endtask

  task automatic drain_chk(input string n, input logic [AW-1:0] v,
                           input logic o);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk({n, "_c"}, c_out, v);
    chk({n, "_cv"}, c_valid_out, 1'b1);
    chk({n, "_ovf"}, c_ovf_out, o);
  endtask

  initial begin
    #12;
    chk("rst_c_out", c_out, 0);
    chk("rst_a_out", a_out, 0);
    chk("rst_orun", res_overrun, 0);
    started = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    cyc(3, 4, 1, 1, 0, 0, 0);
    chk("fwd_a", a_out, 3);
    chk("fwd_b", b_out, 4);
    chk("fwd_av", a_valid_out, 1);
    cyc(2, 5, 1, 1, 0, 0, 0);
    cyc(1, 6, 1, 1, 1, 0, 0);
    drain_chk("u28", 28, 0);

    signed_mode = 1;
    cyc(8'hFD, 4, 1, 1, 0, 0, 0);
    cyc(2, 8'hFB, 1, 1, 1, 0, 0);
    drain_chk("s_m22", 16'hFFEA, 0);
    signed_mode = 0;
    cyc(253, 4, 1, 1, 0, 0, 0);
    cyc(2, 251, 1, 1, 1, 0, 0);
    drain_chk("u1514", 1514, 0);

    sat_en = 1;
    cyc(255, 255, 1, 1, 0, 0, 0);
    cyc(255, 255, 1, 1, 1, 0, 0);
    drain_chk("usat", 65535, 1);
    sat_en = 0;
    cyc(255, 255, 1, 1, 0, 0, 0);
    cyc(255, 255, 1, 1, 1, 0, 0);
    drain_chk("uwrap", 64514, 1);

    signed_mode = 1; sat_en = 1;
    for (int i = 0; i < 4; i++)
      cyc(8'h80, 8'h80, 1, 1, i == 3, 0, 0);
    drain_chk("ssat", 32767, 1);
    cyc(1, 1, 1, 1, 1, 0, 0);
    drain_chk("snext", 1, 0);
    signed_mode = 0; sat_en = 0;

    cyc(3, 4, 1, 1, 0, 0, 0);
    cyc(7, 7, 0, 1, 0, 0, 0);
    cyc(7, 7, 1, 0, 0, 0, 0);
    en = 0;
    for (int i = 0; i < 3; i++) cyc(9, 9, 1, 1, 1, 1, 1);
    chk("frozen_a", a_out, 7);
    chk("frozen_c", c_out, 1);
    en = 1;
    cyc(2, 5, 1, 1, 0, 0, 0);
    cyc(1, 6, 1, 1, 1, 0, 0);
    drain_chk("stall", 28, 0);

    c_in = 16'h1234; c_valid_in = 1;
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("shift_c", c_out, 16'h1234);
    chk("shift_cv", c_valid_out, 1);
    c_in = '0; c_valid_in = 0;

    chk("orun_pre", res_overrun, 0);
    cyc(1, 1, 1, 1, 1, 0, 0);
    cyc(2, 2, 1, 1, 1, 0, 0);
    chk("orun", res_overrun, 1);

    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) begin
        signed_mode = 1'($urandom);
        sat_en = 1'($urandom);
      end
      en = ($urandom_range(0, 9) != 0);
      c_in = 16'($urandom);
      c_valid_in = 1'($urandom);
      c_ovf_in = 1'($urandom);
      cyc(8'($urandom), 8'($urandom),
          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
          $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 2) == 0);
    end

    en = 1;
    cyc(5, 5, 1, 1, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("mrst_a", a_out, 0);
    chk("mrst_av", a_valid_out, 0);
    chk("mrst_c", c_out, 0);
    chk("mrst_cv", c_valid_out, 0);
    chk("mrst_orun", res_overrun, 0);
    @(negedge clk);
    rst_n = 1;
    cyc(4, 4, 1, 1, 1, 0, 0);
    drain_chk("post_rst", 16, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
